stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 157 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control block for a centisecond stopwatch. Two bouncing, active-low
//   pushbuttons (start/stop and lap/clear) are synchronized, debounced and
//   edge-detected into one-cycle press events. These events drive a four-state
//   FSM that enables the counter chain, freezes the display and clears the
//   counters.
//
// Parameters
//   DEBOUNCE_CYCLES : number of consecutive synchronized cycles a new key
//                     level must hold before it is accepted
//   CNT_W           : debounce counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous reset, active-low
//   key_start in   start/stop button, active-low, asynchronous
//   key_lap   in   lap/clear button, active-low, asynchronous
//   run_en    out  count enable to the centisecond counter chain
//   clr_n     out  one-cycle active-low clear to the counter chain
//   lap_hold  out  display freeze request to the digit latch
//   state     out  FSM state: IDLE=00, RUN=01, LAP=10, STOP=11
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_start,
   input  logic       key_lap,
   output logic       run_en,
   output logic       clr_n,
   output logic       lap_hold,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_LAP  = 2'b10,
      ST_STOP = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Bit 0 carries the start key, bit 1 the lap key throughout.
   // Synchronizer flops hold raw (active-low) levels; 1 means released.
   logic [1:0]       sync1_q, sync1_d;
   logic [1:0]       sync2_q, sync2_d;
   // Debounced levels in press polarity (1 = pressed).
   logic [1:0]       stable_q, stable_d;
   logic [1:0]       stable_dly_q, stable_dly_d;
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic [1:0]       key_lvl;
   logic [1:0]       press;

   state_t           state_q, state_d;
   logic             run_en_q, run_en_d;
   logic             lap_hold_q, lap_hold_d;
   logic             clr_n_q, clr_n_d;

   // Key conditioning: synchronize, invert, debounce, rising-edge detect
   always_comb begin
      sync1_d      = {key_lap, key_start};
      sync2_d      = sync1_q;
      key_lvl      = ~sync2_q;
      stable_d     = stable_q;
      stable_dly_d = stable_q;
      for (int i = 0; i < 2; i++) begin
         // Counter runs only while the synchronized level disagrees with the
         // accepted level; any agreeing cycle restarts the qualification.
         cnt_d[i] = '0;
         if (key_lvl[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = key_lvl[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
      // Rising edge only, so releases and long holds give no extra event.
      press = stable_q & ~stable_dly_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q      <= 2'b11;
         sync2_q      <= 2'b11;
         stable_q     <= 2'b00;
         stable_dly_q <= 2'b00;
         cnt_q[0]     <= '0;
         cnt_q[1]     <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         cnt_q[0]     <= cnt_d[0];
         cnt_q[1]     <= cnt_d[1];
      end
   end

   // FSM next state; start is tested first so it wins over a same-cycle lap
   always_comb begin
      state_d = state_q;
      clr_n_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (press[0]) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (press[0])      state_d = ST_STOP;
            else if (press[1]) state_d = ST_LAP;
         end
         ST_LAP: begin
            if (press[0])      state_d = ST_STOP;
            else if (press[1]) state_d = ST_RUN;
         end
         ST_STOP: begin
            if (press[0]) begin
               state_d = ST_RUN;
            end else if (press[1]) begin
               state_d = ST_IDLE;
               clr_n_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Outputs are registered alongside the state so they never glitch
      // on multi-bit state transitions (e.g. RUN 01 -> LAP 10).
      run_en_d   = (state_d == ST_RUN) || (state_d == ST_LAP);
      lap_hold_d = (state_d == ST_LAP);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         run_en_q   <= 1'b0;
         lap_hold_q <= 1'b0;
         clr_n_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         run_en_q   <= run_en_d;
         lap_hold_q <= lap_hold_d;
         clr_n_q    <= clr_n_d;
      end
   end

   assign state    = state_q;
   assign run_en   = run_en_q;
   assign lap_hold = lap_hold_q;
   assign clr_n    = clr_n_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Scoreboard bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4. The driver
//   applies one input vector per clock, advances a reference model and pushes
//   the expected outputs; a monitor pops and compares after every edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_start = 1'b1;
   logic       key_lap = 1'b1;
   logic       run_en;
   logic       clr_n;
   logic       lap_hold;
   logic [1:0] state;

   always #5 clk = ~clk;

   stopwatch_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_start(key_start),
      .key_lap  (key_lap),
      .run_en   (run_en),
      .clr_n    (clr_n),
      .lap_hold (lap_hold),
      .state    (state)
   );

   int         checks = 0;
   int         failures = 0;
   logic [4:0] exp_q [$];

   // Reference model: key history in press polarity (1 = pressed), one entry
   // per clock edge, oldest first. A level is accepted once it was presented
   // for D consecutive edges, seen through two flops of synchronizer delay.
   int         m_state = 0;
   bit         m_clr = 1'b1;
   bit [1:0]   m_st = 2'b00;
   bit [1:0]   m_pend = 2'b00;
   bit         hist0 [$];
   bit         hist1 [$];

   task automatic model_step(input bit r, input bit ks, input bit kl);
      bit old_lvl;
      bit flip;
      bit v;
      if (!r) begin
         m_state = 0;
         m_clr   = 1'b1;
         m_st    = 2'b00;
         m_pend  = 2'b00;
         hist0.delete();
         hist1.delete();
         for (int j = 0; j <= D; j++) begin
            hist0.push_back(1'b0);
            hist1.push_back(1'b0);
         end
      end else begin
         m_clr = 1'b1;
         if (m_pend[0]) begin
            case (m_state)
               0: m_state = 1;
               1: m_state = 3;
               2: m_state = 3;
               default: m_state = 1;
            endcase
         end else if (m_pend[1]) begin
            case (m_state)
               1: m_state = 2;
               2: m_state = 1;
               3: begin m_state = 0; m_clr = 1'b0; end
               default: m_state = m_state;
            endcase
         end
         // Window of the D samples taken 2..D+1 edges ago.
         for (int k = 0; k < 2; k++) begin
            old_lvl = m_st[k];
            flip = 1'b1;
            for (int j = 0; j < D; j++) begin
               v = (k == 0) ? hist0[j] : hist1[j];
               if (v == old_lvl) flip = 1'b0;
            end
            if (flip) m_st[k] = ~old_lvl;
            m_pend[k] = m_st[k] & ~old_lvl;
         end
         hist0.push_back(~ks);
         hist1.push_back(~kl);
         void'(hist0.pop_front());
         void'(hist1.pop_front());
      end
      exp_q.push_back({2'(m_state), (m_state == 1 || m_state == 2), (m_state == 2), m_clr});
   endtask

   task automatic cyc(input bit r, input bit ks, input bit kl);
      @(negedge clk);
      rst       = r;
      key_start = ks;
      key_lap   = kl;
      @(posedge clk);
      model_step(r, ks, kl);
   endtask

   task automatic hold(input int n, input bit ks, input bit kl);
      for (int i = 0; i < n; i++) cyc(1'b1, ks, kl);
   endtask

   // Monitor: compare after every edge that has an expectation queued
   initial begin
      logic [4:0] e;
      logic [4:0] a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {state, run_en, lap_hold, clr_n};
            checks++;
            if (a !== e) begin
               failures++;
               $display("FAIL outputs t=%0t actual state=%b run_en=%b lap_hold=%b clr_n=%b required state=%b run_en=%b lap_hold=%b clr_n=%b",
                        $time, a[4:3], a[2], a[1], a[0], e[4:3], e[2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len;
      bit ks;
      bit kl;
      bit r;
      // Reset
      repeat (3) cyc(1'b0, 1'b1, 1'b1);
      // Bounce shorter than qualification time
      hold(3, 1'b0, 1'b1);
      hold(12, 1'b1, 1'b1);
      // Start press held, then released
      hold(20, 1'b0, 1'b1);
      hold(10, 1'b1, 1'b1);
      // Lap in, lap out
      hold(8, 1'b1, 1'b0);
      hold(8, 1'b1, 1'b1);
      hold(8, 1'b1, 1'b0);
      hold(8, 1'b1, 1'b1);
      // Stop, then clear back to idle
      hold(8, 1'b0, 1'b1);
      hold(8, 1'b1, 1'b1);
      hold(8, 1'b1, 1'b0);
      hold(8, 1'b1, 1'b1);
      // Run again, then both keys on the same edge
      hold(8, 1'b0, 1'b1);
      hold(8, 1'b1, 1'b1);
      hold(8, 1'b0, 1'b0);
      hold(8, 1'b1, 1'b1);
      // Run, then reset mid-run
      hold(8, 1'b0, 1'b1);
      hold(8, 1'b1, 1'b1);
      hold(3, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);
      hold(8, 1'b1, 1'b1);
      // Key held through reset: restarts qualification after release of rst
      hold(3, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      hold(12, 1'b0, 1'b1);
      hold(8, 1'b1, 1'b1);
      // Randomized segments of held levels with occasional reset
      for (int s = 0; s < 400; s++) begin
         len = $urandom_range(1, 9);
         ks  = ($urandom_range(0, 2) == 0);
         kl  = ($urandom_range(0, 2) == 0);
         r   = ($urandom_range(0, 59) != 0);
         for (int i = 0; i < len; i++) cyc((i == 0) ? r : 1'b1, ks, kl);
      end
      hold(10, 1'b1, 1'b1);
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
